// File: rtl/toy_pkg.sv
// Shared definitions for the 16-bit toy CPU control unit.
// Holds the opcode map, the ALU operation codes, the controller state type,
// the instruction field bit positions and a small immediate helper.
package toy_pkg;

    // Instruction opcodes, ir[15:12]
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_BZ  = 4'b1010;
    localparam logic [3:0] OP_BC  = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // ALU operation codes driven on alu_op
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SHL = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    // Instruction field bit positions
    localparam int unsigned OP_MSB    = 15;
    localparam int unsigned OP_LSB    = 12;
    localparam int unsigned RD_MSB    = 11;
    localparam int unsigned RD_LSB    = 9;
    localparam int unsigned RS_MSB    = 8;
    localparam int unsigned RS_LSB    = 6;
    localparam int unsigned RT_MSB    = 5;
    localparam int unsigned RT_LSB    = 3;
    localparam int unsigned IMM9_MSB  = 8;
    localparam int unsigned IMM12_MSB = 11;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_e;

    // Sign-extend a 9-bit branch offset to 16 bits
    function automatic logic [15:0] sext_imm9(input logic [8:0] imm);
        return {{7{imm[8]}}, imm};
    endfunction

endpackage

// File: rtl/toy_decode.sv
// Combinational opcode decoder for the toy CPU controller.
// Ports:
//   op         in  4  instruction opcode, ir[15:12]
//   alu_op     out 3  ALU operation for ALU-class opcodes (ALU_ADD otherwise)
//   is_alu     out 1  ADD/SUB/SHL/XOR/OR/AND
//   is_ld      out 1  LD
//   is_st      out 1  ST
//   is_br      out 1  BZ or BC
//   is_jmp     out 1  JMP
//   is_hlt     out 1  HLT
//   is_illegal out 1  any unassigned opcode
module toy_decode
    import toy_pkg::*;
(
    input  logic [3:0] op,
    output logic [2:0] alu_op,
    output logic       is_alu,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_br,
    output logic       is_jmp,
    output logic       is_hlt,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        is_alu     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_br      = 1'b0;
        is_jmp     = 1'b0;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        unique case (op)
            OP_ADD: begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_SHL: begin is_alu = 1'b1; alu_op = ALU_SHL; end
            OP_XOR: begin is_alu = 1'b1; alu_op = ALU_XOR; end
            OP_OR:  begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_AND: begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_LD:  is_ld  = 1'b1;
            OP_ST:  is_st  = 1'b1;
            OP_BZ,
            OP_BC:  is_br  = 1'b1;
            OP_JMP: is_jmp = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/toy_ctrl.sv
// Multi-cycle control unit for the 16-bit toy CPU.
// Fetches over a req/ack memory port, decodes, and sequences the ALU,
// register file and load/store accesses. Holds PC, IR and the Z/C flags.
// Build option: define TOY_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT
// with a sticky 'illegal' flag; otherwise illegal opcodes execute as NOPs.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_req/we/addr        memory request, store select, address (held until ack)
//   mem_ack, mem_rdata     access complete, instruction or load data
//   rf_a_sel/rf_b_sel      register read selects (rs, rt)
//   rf_a_data              port A data, used as LD/ST address
//   rf_w_sel, rf_we        register write select (rd) and one-cycle strobe
//   wb_sel                 write-back source: 0 ALU, 1 load data
//   alu_op, alu_z, alu_c   ALU operation and its flag outputs
//   pc_out, halted         current PC, controller halted
//   illegal                illegal-opcode trap indication
module toy_ctrl
    import toy_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        rf_a_sel,
    output logic [2:0]        rf_b_sel,
    input  logic [DATA_W-1:0] rf_a_data,
    output logic [2:0]        rf_w_sel,
    output logic              rf_we,
    output logic              wb_sel,
    output logic [2:0]        alu_op,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic [DATA_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic [2:0]        alu_op_q, alu_op_d;
`ifdef TOY_ILLEGAL_TRAP_EN
    logic              illegal_q, illegal_d;
`endif

    logic [2:0] dec_alu_op;
    logic       dec_is_alu, dec_is_ld, dec_is_st, dec_is_br;
    logic       dec_is_jmp, dec_is_hlt, dec_is_illegal;
    logic       br_taken;

    toy_decode u_decode (
        .op         (ir_q[OP_MSB:OP_LSB]),
        .alu_op     (dec_alu_op),
        .is_alu     (dec_is_alu),
        .is_ld      (dec_is_ld),
        .is_st      (dec_is_st),
        .is_br      (dec_is_br),
        .is_jmp     (dec_is_jmp),
        .is_hlt     (dec_is_hlt),
        .is_illegal (dec_is_illegal)
    );

    // BZ and BC differ only in which flag they test
    assign br_taken = (ir_q[OP_MSB:OP_LSB] == OP_BC) ? c_q : z_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        z_d      = z_q;
        c_d      = c_q;
        alu_op_d = alu_op_q;
`ifdef TOY_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + DATA_W'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_is_alu) begin
                    state_d = EXEC;
                end else if (dec_is_ld || dec_is_st) begin
                    state_d = MEM;
                end else if (dec_is_br) begin
                    // pc already points past the branch word
                    if (br_taken) begin
                        pc_d = pc_q + sext_imm9(ir_q[IMM9_MSB:0]);
                    end
                    state_d = FETCH;
                end else if (dec_is_jmp) begin
                    pc_d    = {pc_q[15:12], ir_q[IMM12_MSB:0]};
                    state_d = FETCH;
                end else if (dec_is_hlt) begin
                    state_d = HALT;
                end else if (dec_is_illegal) begin
`ifdef TOY_ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = HALT;
`else
                    state_d   = FETCH;
`endif
                end
            end
            EXEC: begin
                alu_op_d = dec_alu_op;
                z_d      = alu_z;
                c_d      = alu_c;
                state_d  = WB;
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = dec_is_ld ? WB : FETCH;
                end
            end
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            alu_op_q <= ALU_ADD;
`ifdef TOY_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            z_q      <= z_d;
            c_q      <= c_d;
            alu_op_q <= alu_op_d;
`ifdef TOY_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Outputs are forced to their reset values while rst is high so that an
    // in-flight access is dropped in the reset cycle itself.
    always_comb begin
        mem_req  = !rst && (state_q == FETCH || state_q == MEM);
        mem_we   = !rst && (state_q == MEM) && dec_is_st;
        mem_addr = rst ? RESET_PC : ((state_q == MEM) ? rf_a_data : pc_q);
        rf_a_sel = rst ? 3'd0 : ir_q[RS_MSB:RS_LSB];
        rf_b_sel = rst ? 3'd0 : ir_q[RT_MSB:RT_LSB];
        rf_w_sel = rst ? 3'd0 : ir_q[RD_MSB:RD_LSB];
        rf_we    = !rst && (state_q == WB);
        wb_sel   = !rst && (state_q == WB) && dec_is_ld;
        alu_op   = rst ? ALU_ADD : ((state_q == EXEC) ? dec_alu_op : alu_op_q);
        pc_out   = rst ? RESET_PC : pc_q;
        halted   = !rst && (state_q == HALT);
`ifdef TOY_ILLEGAL_TRAP_EN
        illegal  = !rst && illegal_q;
`else
        illegal  = 1'b0;
`endif
    end

endmodule

// File: doc/toy_ctrl.md
Name: toy_ctrl

Overview:
- Multi-cycle control unit for the 16-bit toy CPU.
- Fetches instructions over a request/acknowledge memory port, decodes them, and sequences the shared ALU, register file and load/store accesses.
- Holds PC, IR and the Z/C flags. Drives alu_op and all register-file and memory control.
- Contains no datapath arithmetic beyond PC increment and branch target.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- DATA_W, 16, instruction, data and address width. Only 16 is supported.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  memory access request, held until mem_ack
- mem_we  out  1  1 = store, 0 = fetch/load
- mem_addr  out  16  memory address (PC for fetch, rf_a_data for LD/ST)
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle
- mem_rdata  in  16  fetched instruction or load data
- rf_a_sel  out  3  register-file read port A select (ir[8:6], rs)
- rf_b_sel  out  3  register-file read port B select (ir[5:3], rt)
- rf_a_data  in  16  port A data, used as LD/ST address
- rf_w_sel  out  3  write select (ir[11:9], rd)
- rf_we  out  1  register write strobe, one cycle
- wb_sel  out  1  0 = ALU result, 1 = load data
- alu_op  out  3  ALU operation code
- alu_z  in  1  ALU zero flag
- alu_c  in  1  ALU carry flag
- pc_out  out  16  current PC
- halted  out  1  controller is in HALT
- illegal  out  1  illegal-opcode trap; see Optional Feature

Behaviour:
- Instruction format: op = ir[15:12], rd = ir[11:9], rs = ir[8:6], rt = ir[5:3], imm9 = ir[8:0], imm12 = ir[11:0].
- ALU opcodes: 0000 ADD -> alu_op 000; 0001 SUB -> 001; 0100 SHL -> 100; 0101 XOR -> 101; 0110 OR -> 110; 0111 AND -> 111.
- Memory opcodes: 1000 LD rd <- M[rs]; 1001 ST M[rs] <- rt. The store data path to memory is external.
- Control-flow opcodes: 1010 BZ; 1011 BC; 1100 JMP; 1111 HLT. All other opcodes are illegal.
- Reset (sync, synchronous to clk): state = FETCH, pc = RESET_PC, ir = 0, z = c = 0. All outputs are 0, except pc_out = RESET_PC and mem_addr = RESET_PC. Reset overrides any in-flight access; a mem_ack arriving in the reset cycle is discarded.
- FETCH: mem_req = 1, mem_we = 0, mem_addr = pc. Stay in FETCH until mem_ack. On ack: ir <= mem_rdata, pc <= pc + 1 (wraps 16'hFFFF -> 0), go to DECODE.
- DECODE (1 cycle): rf selects driven from ir.
  - ALU op -> EXEC.
  - LD/ST -> MEM.
  - BZ: if z, pc <= pc + sext(imm9), modulo 2^16, relative to the incremented PC. Go to FETCH.
  - BC: same as BZ, conditioned on c.
  - JMP: pc <= {pc[15:12], imm12}. Go to FETCH.
  - HLT -> HALT.
  - Illegal -> per Optional Feature.
- EXEC (1 cycle): alu_op driven. z <= alu_z, c <= alu_c latched at the end of the cycle. Go to WB.
- MEM: mem_req = 1, mem_addr = rf_a_data, mem_we = 1 for ST. Hold until mem_ack.
  - LD: on ack, go to WB with wb_sel = 1. Load data is captured externally on rf_we.
  - ST: on ack, go to FETCH.
- WB (1 cycle): rf_we = 1, wb_sel = 0 for ALU ops, 1 for LD. Go to FETCH.
- HALT: halted = 1, no requests. Remains in HALT until rst.
- Interface invariants:
  - mem_req, mem_we and mem_addr are stable while waiting for ack.
  - mem_ack while mem_req = 0 is ignored.
  - At most one access is outstanding.
- Flag invariants:
  - Flags change only in EXEC.
  - LD/ST/branches/JMP leave the flags unchanged.
  - alu_op holds the last value outside EXEC; the ALU result is don't-care outside EXEC/WB.
- Cycle counts, with zero-wait memory (ack in the first request cycle): ALU op 4 cycles (FETCH, DECODE, EXEC, WB); LD 4; ST 3; branch/JMP 2.

Optional Feature:
- Macro: TOY_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode goes to HALT with illegal = 1 (sticky until rst). pc is left pointing past the faulting word.
- Undefined: an illegal opcode is executed as a NOP (DECODE -> FETCH, no state change), and illegal is tied to 0.

Decomposition:
- Shared package toy_pkg holds:
  - the opcode localparams (OP_ADD ... OP_HLT);
  - the ALU op codes (ALU_ADD = 3'b000 ... ALU_AND = 3'b111);
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - instruction field bit positions.
- Sub-module toy_decode (combinational): op -> {alu_op, is_alu, is_ld, is_st, is_br, is_jmp, is_hlt, is_illegal}.
- The FSM, PC, IR and flag registers stay in toy_ctrl.

Test Plan:
- Reset, then fetch with mem_ack delayed 3 cycles -> mem_req stays high with mem_addr = 0x0000 for 4 cycles; ir loaded; pc = 0x0001.
- ADD r1,r2,r3 (0x0298), alu_z = 0, alu_c = 1 in EXEC -> alu_op = 000; rf_we pulses once in WB with rf_w_sel = 1, wb_sel = 0; c = 1, z = 0; instruction done in 4 cycles.
- pc = 0x0010, BZ imm9 = 0x1FE (-2) with z = 1 -> next fetch address 0x000F. Same instruction with z = 0 -> next fetch address 0x0011.
- LD r4,[r5] with rf_a_data = 0xFFFF and ack in 1 cycle -> mem_addr = 0xFFFF, mem_we = 0, then WB with wb_sel = 1, rf_w_sel = 4. ST -> mem_we = 1, no rf_we.
- Opcode 0x2xxx -> with TOY_ILLEGAL_TRAP_EN: halted = 1, illegal = 1, no further mem_req. Without the macro: NOP, next fetch at pc + 1.
- rst asserted during MEM wait with mem_ack arriving in the same cycle -> next cycle state = FETCH, pc = RESET_PC, rf_we = 0, flags cleared.
